// File: rtl/hazard_ctrl.sv
// Hazard, stall/flush and forwarding controller for the 5-stage RV32I pipe.
// Freezes the pipe on multi-cycle data-memory accesses and aborts on timeout.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_rs1D,
    input  logic [4:0]       i_rs2D,
    input  logic [4:0]       i_rs1E,
    input  logic [4:0]       i_rs2E,
    input  logic [4:0]       i_rdE,
    input  logic             i_rd_wrenE,
    input  logic             i_is_loadE,
    input  logic             i_br_takenE,
    input  logic [4:0]       i_rdM,
    input  logic             i_rd_wrenM,
    input  logic             i_mem_reqM,
    input  logic             i_mem_ackM,
    input  logic [4:0]       i_rdWB,
    input  logic             i_rd_wrenWB,
    output logic             o_stallF,
    output logic             o_stallD,
    output logic             o_stallE,
    output logic             o_stallM,
    output logic             o_flushD,
    output logic             o_flushE,
    output logic             o_flushWB,
    output logic [1:0]       o_fwd_aE,
    output logic [1:0]       o_fwd_bE,
    output logic             o_mem_err,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_wait, load_use;

    // MEM stage holds the younger result, so it wins over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       wrenM,
        input logic [4:0] rdWB,
        input logic       wrenWB
    );
        if (wrenM && rdM != 5'd0 && rdM == rs)
            return 2'b10;
        else if (wrenWB && rdWB != 5'd0 && rdWB == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign o_fwd_aE = fwd_sel(i_rs1E, i_rdM, i_rd_wrenM, i_rdWB, i_rd_wrenWB);
    assign o_fwd_bE = fwd_sel(i_rs2E, i_rdM, i_rd_wrenM, i_rdWB, i_rd_wrenWB);

    assign mem_wait = i_mem_reqM && !i_mem_ackM;
    assign load_use = i_is_loadE && i_rd_wrenE && (i_rdE != 5'd0) &&
                      ((i_rdE == i_rs1D) || (i_rdE == i_rs2D));

    always_comb begin
        o_stallF  = 1'b0;
        o_stallD  = 1'b0;
        o_stallE  = 1'b0;
        o_stallM  = 1'b0;
        o_flushD  = 1'b0;
        o_flushE  = 1'b0;
        o_flushWB = 1'b0;
        o_mem_err = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    {o_stallF, o_stallD, o_stallE, o_stallM} = 4'b1111;
                    o_flushWB = 1'b1;
                    state_d   = ST_WAIT;
                    wait_d    = WAIT_W'(1);
                end else if (i_br_takenE) begin
                    o_flushD = 1'b1;
                    o_flushE = 1'b1;
                end else if (load_use) begin
                    o_stallF = 1'b1;
                    o_stallD = 1'b1;
                    o_flushE = 1'b1;
                end
            end
            // Branch and load-use are ignored here: E is frozen and they re-evaluate on exit.
            ST_WAIT: begin
                if (i_mem_ackM) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    {o_stallF, o_stallD, o_stallE, o_stallM} = 4'b1111;
                    o_flushWB = 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT))
                        state_d = ST_ERR;
                    else
                        wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                o_mem_err = 1'b1;
                o_flushD  = 1'b1;
                o_flushE  = 1'b1;
                o_flushWB = 1'b1;
                state_d   = ST_RUN;
                wait_d    = '0;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (o_stallF && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (o_flushE && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a rule-level reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int SAT     = (1 << CW) - 1;

    logic          clk, rst;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdWB;
    logic          rdWrenE, isLoadE, brTakenE, rdWrenM, memReqM, memAckM, rdWrenWB;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushWB, memErr;
    logic [1:0]    fwdA, fwdB, state;
    logic [CW-1:0] stallCnt, flushCnt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1D(rs1D), .i_rs2D(rs2D), .i_rs1E(rs1E), .i_rs2E(rs2E),
        .i_rdE(rdE), .i_rd_wrenE(rdWrenE), .i_is_loadE(isLoadE), .i_br_takenE(brTakenE),
        .i_rdM(rdM), .i_rd_wrenM(rdWrenM), .i_mem_reqM(memReqM), .i_mem_ackM(memAckM),
        .i_rdWB(rdWB), .i_rd_wrenWB(rdWrenWB),
        .o_stallF(stallF), .o_stallD(stallD), .o_stallE(stallE), .o_stallM(stallM),
        .o_flushD(flushD), .o_flushE(flushE), .o_flushWB(flushWB),
        .o_fwd_aE(fwdA), .o_fwd_bE(fwdB), .o_mem_err(memErr), .o_state(state),
        .o_stall_cnt(stallCnt), .o_flush_cnt(flushCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pipeline mode, cycles spent waiting, and saturating event tallies.
    function automatic logic [1:0] modelFwd(input logic [4:0] rs);
        if (rdWrenM && rdM != 0 && rdM == rs) return 2'd2;
        if (rdWrenWB && rdWB != 0 && rdWB == rs) return 2'd1;
        return 2'd0;
    endfunction

    initial begin
        int mode = 0;
        int waited = 0;
        int mStall = 0;
        int mFlush = 0;
        bit valid = 0;
        logic eStallF, eStallD, eStallE, eStallM, eFlushD, eFlushE, eFlushWB, eErr;
        logic [21:0] expV, actV;
        bit luHaz, memBusy;
        forever begin
            @(negedge clk);
            {eStallF, eStallD, eStallE, eStallM, eFlushD, eFlushE, eFlushWB, eErr} = '0;
            memBusy = memReqM && !memAckM;
            luHaz = isLoadE && rdWrenE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
            if (mode == 0) begin
                if (memBusy) {eStallF, eStallD, eStallE, eStallM, eFlushWB} = '1;
                else if (brTakenE) {eFlushD, eFlushE} = '1;
                else if (luHaz) {eStallF, eStallD, eFlushE} = '1;
            end else if (mode == 1) begin
                if (!memAckM) {eStallF, eStallD, eStallE, eStallM, eFlushWB} = '1;
            end else begin
                {eErr, eFlushD, eFlushE, eFlushWB} = '1;
            end
            if (valid) begin
                expV = {eStallF, eStallD, eStallE, eStallM, eFlushD, eFlushE, eFlushWB,
                        modelFwd(rs1E), modelFwd(rs2E), eErr, 2'(mode), CW'(mStall), CW'(mFlush)};
                actV = {stallF, stallD, stallE, stallM, flushD, flushE, flushWB,
                        fwdA, fwdB, memErr, state, stallCnt, flushCnt};
                checks++;
                if (actV !== expV) begin
                    errors++;
                    $display("[TB] FAIL model t=%0t got=%h want=%h", $time, actV, expV);
                end
            end
            @(posedge clk);
            if (rst) begin
                mode = 0; waited = 0; mStall = 0; mFlush = 0; valid = 1;
            end else begin
                if (eStallF && mStall < SAT) mStall++;
                if (eFlushE && mFlush < SAT) mFlush++;
                case (mode)
                    0: if (memBusy) begin mode = 1; waited = 1; end
                    1: if (memAckM) begin mode = 0; waited = 0; end
                       else if (waited == TIMEOUT) mode = 2;
                       else waited++;
                    default: mode = 0;
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdWB} = '0;
        {rdWrenE, isLoadE, brTakenE, rdWrenM, memReqM, memAckM, rdWrenWB} = '0;
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        applyStimulus(2);
        rst = 1'b0;
        #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_outs", {stallF, stallD, stallE, stallM, flushD, flushE, flushWB, fwdA, fwdB, memErr}, 0);
        checkOutput("reset_cnts", {stallCnt, flushCnt}, 0);

        // Forwarding priority
        rdWrenM = 1; rdM = 5; rdWrenWB = 1; rdWB = 5; rs1E = 5; rs2E = 0; #1;
        checkOutput("fwd_mem", fwdA, 2);
        checkOutput("fwd_x0", fwdB, 0);
        rdWrenM = 0; #1;
        checkOutput("fwd_wb", fwdA, 1);
        rdM = 0; rdWB = 0; #1;
        checkOutput("fwd_none", fwdA, 0);
        rdWrenM = 1; rdM = 9; rdWB = 9; rs2E = 9; rs1E = 3; #1;
        checkOutput("fwd_b_mem", fwdB, 2);
        applyStimulus(1);
        clearInputs();

        // Load-use stalls for exactly one cycle
        isLoadE = 1; rdWrenE = 1; rdE = 7; rs2D = 7; #1;
        checkOutput("lu_stall", {stallF, stallD, stallE, flushE}, 4'b1101);
        applyStimulus(1);
        clearInputs(); #1;
        checkOutput("lu_cleared", stallF, 0);
        checkOutput("lu_cnts", {stallCnt, flushCnt}, {4'd1, 4'd1});
        isLoadE = 1; rdWrenE = 1; rdE = 0; rs1D = 0; #1;
        checkOutput("lu_x0", stallF, 0);
        applyStimulus(1);

        // Branch kills the load-use consumer
        clearInputs();
        isLoadE = 1; rdWrenE = 1; rdE = 7; rs1D = 7; brTakenE = 1; #1;
        checkOutput("br_over_lu", {stallF, flushD, flushE}, 3'b011);
        applyStimulus(1);
        clearInputs(); #1;
        checkOutput("br_cnts", {stallCnt, flushCnt}, {4'd1, 4'd2});

        // Memory wait of three stalled cycles, released on ack
        memReqM = 1; #1;
        checkOutput("mw_enter", {stallF, stallM, flushWB, state}, {3'b111, 2'd0});
        applyStimulus(1);
        brTakenE = 1; #1;
        checkOutput("mw_wait1", {stallF, flushD, state}, {2'b10, 2'd1});
        applyStimulus(1);
        brTakenE = 0;
        checkOutput("mw_wait2", {stallE, state}, {1'b1, 2'd1});
        applyStimulus(1);
        memAckM = 1; #1;
        checkOutput("mw_release", {stallF, stallD, stallE, stallM, flushWB, state}, {5'b0, 2'd1});
        applyStimulus(1);
        clearInputs(); #1;
        checkOutput("mw_done", {state, stallCnt, flushCnt}, {2'd0, 4'd4, 4'd2});

        // Timeout: four waiting cycles, then a single error cycle
        memReqM = 1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus(1);
            checkOutput("to_wait", {state, stallF}, {2'd1, 1'b1});
        end
        applyStimulus(1);
        memReqM = 0; #1;
        checkOutput("to_err", {state, memErr, flushD, flushE, flushWB, stallF}, {2'd2, 5'b11110});
        applyStimulus(1);
        checkOutput("to_back", {state, memErr}, {2'd0, 1'b0});
        checkOutput("to_cnts", {stallCnt, flushCnt}, {4'd9, 4'd3});

        // Ack coinciding with the timeout compare wins
        memReqM = 1;
        applyStimulus(TIMEOUT);
        memAckM = 1; #1;
        checkOutput("ack_at_to", {state, stallF}, {2'd1, 1'b0});
        applyStimulus(1);
        clearInputs(); #1;
        checkOutput("ack_no_err", {state, memErr, stallCnt}, {2'd0, 1'b0, 4'd13});

        // Counter saturation under a held load-use condition
        isLoadE = 1; rdWrenE = 1; rdE = 4; rs1D = 4;
        applyStimulus(20);
        clearInputs(); #1;
        checkOutput("sat_cnts", {stallCnt, flushCnt}, {4'(SAT), 4'(SAT)});

        // Reset in the second MEM_WAIT cycle
        memReqM = 1;
        applyStimulus(2);
        checkOutput("rst_wait", state, 1);
        rst = 1;
        applyStimulus(1);
        rst = 0; memReqM = 0; #1;
        checkOutput("rst_mid", {state, stallF, memErr, stallCnt, flushCnt}, 0);
        applyStimulus(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
